// File: rtl/latch_seq_pkg.sv
// Shared definitions for the latch bank sequencer: FSM state encodings and
// the gate-open counter width.
package latch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/latch_seq_rr_arb.sv
// Combinational requester arbiter: round-robin from ptr_i by default, or
// fixed lowest-index priority when LATCH_SEQ_FIXED_PRIO_EN is defined.
module latch_seq_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
`ifndef LATCH_SEQ_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [NREQ-1:0]  gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic found;
`ifndef LATCH_SEQ_FIXED_PRIO_EN
    int   idx;
`endif

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
`ifdef LATCH_SEQ_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[k]) begin
                found        = 1'b1;
                gnt_oh_o[k]  = 1'b1;
                gnt_idx_o    = IDX_W'(k);
            end
        end
`else
        idx = 0;
        // Scan starting at the pointer, wrapping modulo NREQ.
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_oh_o[idx]  = 1'b1;
                gnt_idx_o      = IDX_W'(idx);
            end
        end
`endif
    end

endmodule

// File: rtl/latch_bank_sequencer.sv
// Shares a bank of level-sensitive latch words among NREQ requesters using a
// setup / gate-open / hold write sequence. Define LATCH_SEQ_FIXED_PRIO_EN for
// fixed lowest-index priority instead of round-robin arbitration.
module latch_bank_sequencer
    import latch_seq_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter int OPEN_CYC = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*WIDTH-1:0]    Wdata,
    input  logic [NREQ*ADDR_W-1:0]   Waddr,
    output logic [NREQ-1:0]          Gnt,
    output logic [NREQ-1:0]          Done,
    output logic [WIDTH-1:0]         LatD,
    output logic [(1<<ADDR_W)-1:0]   LatEn,
    output logic                     Busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int NWORD = 1 << ADDR_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     win_q, win_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NWORD-1:0]    lat_en_q, lat_en_d;
    logic [NREQ-1:0]     arb_oh;
    logic [IDX_W-1:0]    arb_idx;
`ifndef LATCH_SEQ_FIXED_PRIO_EN
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

    latch_seq_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i     (Req),
`ifndef LATCH_SEQ_FIXED_PRIO_EN
        .ptr_i     (ptr_q),
`endif
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        data_d  = data_q;
        addr_d  = addr_q;
`ifndef LATCH_SEQ_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|Req) begin
                    state_d = SETUP;
                    win_d   = arb_oh;
                    data_d  = Wdata[arb_idx*WIDTH +: WIDTH];
                    addr_d  = Waddr[arb_idx*ADDR_W +: ADDR_W];
`ifndef LATCH_SEQ_FIXED_PRIO_EN
                    ptr_d   = (arb_idx == IDX_W'(NREQ-1)) ? '0 : arb_idx + 1'b1;
`endif
                end
            end
            SETUP: begin
                state_d = OPEN;
                cnt_d   = CNT_W'(OPEN_CYC-1);
            end
            OPEN: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gate enables are registered from next state so the latch gates come
    // straight off flops and cannot glitch on decode.
    generate
        for (genvar gi = 0; gi < NWORD; gi++) begin : g_gate_dec
            assign lat_en_d[gi] = (state_d == OPEN) && (addr_d == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            lat_en_q <= '0;
`ifndef LATCH_SEQ_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            lat_en_q <= lat_en_d;
`ifndef LATCH_SEQ_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Reset closes any open gate at once rather than waiting for the edge.
    assign LatEn = lat_en_q & {NWORD{~Rst}};
    assign LatD  = data_q;
    assign Busy  = (state_q != IDLE);
    assign Gnt   = Busy ? win_q : '0;
    assign Done  = (state_q == HOLD) ? win_q : '0;

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Directed self-checking bench for latch_bank_sequencer (OPEN_CYC 2, 1, 15).
module tb_latch_bank_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  Req;
    logic [31:0] Wdata;
    logic [7:0]  Waddr;
    logic [3:0]  Gnt, Done, LatEn;
    logic [7:0]  LatD;
    logic        Busy;

    logic [3:0]  req1, req15;
    logic [31:0] wdata_b;
    logic [7:0]  waddr_b;
    logic [3:0]  gnt1, done1, laten1, gnt15, done15, laten15;
    logic [7:0]  latd1, latd15;
    logic        busy1, busy15;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    latch_bank_sequencer #(.NREQ(4), .WIDTH(8), .ADDR_W(2), .OPEN_CYC(2)) u_dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Wdata(Wdata), .Waddr(Waddr),
        .Gnt(Gnt), .Done(Done), .LatD(LatD), .LatEn(LatEn), .Busy(Busy)
    );

    latch_bank_sequencer #(.NREQ(4), .WIDTH(8), .ADDR_W(2), .OPEN_CYC(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Req(req1), .Wdata(wdata_b), .Waddr(waddr_b),
        .Gnt(gnt1), .Done(done1), .LatD(latd1), .LatEn(laten1), .Busy(busy1)
    );

    latch_bank_sequencer #(.NREQ(4), .WIDTH(8), .ADDR_W(2), .OPEN_CYC(15)) u_dut15 (
        .Clk(Clk), .Rst(Rst), .Req(req15), .Wdata(wdata_b), .Waddr(waddr_b),
        .Gnt(gnt15), .Done(done15), .LatD(latd15), .LatEn(laten15), .Busy(busy15)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the main DUT outputs.
    task automatic cyc_chk(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic [3:0] le, input logic [7:0] ld, input logic b);
        @(negedge Clk);
        chk({tag, ".gnt"},   Gnt,   g);
        chk({tag, ".done"},  Done,  d);
        chk({tag, ".laten"}, LatEn, le);
        chk({tag, ".latd"},  LatD,  ld);
        chk({tag, ".busy"},  Busy,  b);
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    function automatic int rr_exp(input int k);
`ifdef LATCH_SEQ_FIXED_PRIO_EN
        return 0;
`else
        return k % 4;
`endif
    endfunction

    initial begin
        int w1, w15, d1c, d15c;
        logic ld_bad;
        logic [7:0] dk;
        Rst = 1'b1; Req = '0; Wdata = '0; Waddr = '0;
        req1 = '0; req15 = '0; wdata_b = '0; waddr_b = '0;
        repeat (2) @(negedge Clk);
        chk("rst.gnt", Gnt, 4'h0);
        chk("rst.done", Done, 4'h0);
        chk("rst.latd", LatD, 8'h00);
        chk("rst.laten", LatEn, 4'h0);
        chk("rst.busy", Busy, 1'b0);
        Rst = 1'b0;

        // Single write from requester 1 to word 3.
        @(negedge Clk);
        Req = 4'b0010; Wdata = 32'h0000_A500; Waddr = 8'b00_00_11_00;
        cyc_chk("single.setup", 4'b0010, 4'b0000, 4'b0000, 8'hA5, 1'b1);
        cyc_chk("single.open1", 4'b0010, 4'b0000, 4'b1000, 8'hA5, 1'b1);
        cyc_chk("single.open2", 4'b0010, 4'b0000, 4'b1000, 8'hA5, 1'b1);
        cyc_chk("single.hold",  4'b0010, 4'b0010, 4'b0000, 8'hA5, 1'b1);
        Req = '0;
        cyc_chk("single.idle",  4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b0);
        $display("tx single: req 1 -> word 3 data a5");

        // Reset clears the pointer, then all four requesters held high.
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        Req = 4'b1111; Wdata = 32'h1312_1110; Waddr = 8'b11_10_01_00;
        for (int k = 0; k < 5; k++) begin
            int e;
            e  = rr_exp(k);
            dk = 8'h10 + 8'(e);
            cyc_chk($sformatf("rr%0d.setup", k), oh(e), 4'b0000, 4'b0000, dk, 1'b1);
            cyc_chk($sformatf("rr%0d.open1", k), oh(e), 4'b0000, oh(e),   dk, 1'b1);
            cyc_chk($sformatf("rr%0d.open2", k), oh(e), 4'b0000, oh(e),   dk, 1'b1);
            cyc_chk($sformatf("rr%0d.hold",  k), oh(e), oh(e),   4'b0000, dk, 1'b1);
            if (k == 4) Req = '0;
            cyc_chk($sformatf("rr%0d.idle",  k), 4'b0000, 4'b0000, 4'b0000, dk, 1'b0);
            $display("tx rr%0d: granted requester %0d", k, e);
        end

        // Requester 2 drops Req during OPEN; requester 0 waits. Pointer is 1.
`ifdef LATCH_SEQ_FIXED_PRIO_EN
        Req = 4'b0100;
`else
        Req = 4'b0101;
`endif
        cyc_chk("drop.setup", 4'b0100, 4'b0000, 4'b0000, 8'h12, 1'b1);
        Req = 4'b0001;
        cyc_chk("drop.open1", 4'b0100, 4'b0000, 4'b0100, 8'h12, 1'b1);
        cyc_chk("drop.open2", 4'b0100, 4'b0000, 4'b0100, 8'h12, 1'b1);
        cyc_chk("drop.hold",  4'b0100, 4'b0100, 4'b0000, 8'h12, 1'b1);
        cyc_chk("drop.idle",  4'b0000, 4'b0000, 4'b0000, 8'h12, 1'b0);
        cyc_chk("drop.next",  4'b0001, 4'b0000, 4'b0000, 8'h10, 1'b1);
        Req = '0;
        repeat (4) @(negedge Clk);
        chk("drop.end.busy", Busy, 1'b0);
        $display("tx drop: requester 2 completed, requester 0 granted next");

        // Reset during the second OPEN cycle of requester 1's write.
        Req = 4'b0010;
        cyc_chk("abort.setup", 4'b0010, 4'b0000, 4'b0000, 8'h11, 1'b1);
        cyc_chk("abort.open1", 4'b0010, 4'b0000, 4'b0010, 8'h11, 1'b1);
        @(negedge Clk);
        chk("abort.open2.laten", LatEn, 4'b0010);
        Rst = 1'b1;
        #1;
        chk("abort.laten.imm", LatEn, 4'b0000);
        cyc_chk("abort.after", 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
        Rst = 1'b0;
        Req = 4'b1111;
        cyc_chk("abort.regrant", 4'b0001, 4'b0000, 4'b0000, 8'h10, 1'b1);
        Req = '0;
        repeat (4) @(negedge Clk);
        chk("abort.end.busy", Busy, 1'b0);
        $display("tx abort: reset mid-open, requester 0 granted after");

        // Gate width at OPEN_CYC=1 and 15; LatD must hold while a gate is open.
        wdata_b = 32'h0000_003C; waddr_b = 8'b00_00_00_10;
        req1 = 4'b0001; req15 = 4'b0001;
        w1 = 0; w15 = 0; d1c = 0; d15c = 0; ld_bad = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge Clk);
            if (|laten1) begin
                w1++;
                if (laten1 !== 4'b0100 || latd1 !== 8'h3C) ld_bad = 1'b1;
            end
            if (|laten15) begin
                w15++;
                if (laten15 !== 4'b0100 || latd15 !== 8'h3C) ld_bad = 1'b1;
            end
            if (done1[0])  begin d1c++;  req1  = '0; end
            if (done15[0]) begin d15c++; req15 = '0; end
        end
        chk("oc1.width", w1, 1);
        chk("oc15.width", w15, 15);
        chk("oc1.done", d1c, 1);
        chk("oc15.done", d15c, 1);
        chk("oc.latd_stable", ld_bad, 1'b0);
        chk("oc.busy", {busy1, busy15}, 2'b00);
        $display("tx open_cyc: widths %0d and %0d", w1, w15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/latch_bank_sequencer.md
# latch_bank_sequencer

Sequences and shares a bank of level-sensitive 1-bit D latches, organised as 2^ADDR_W words of WIDTH bits, among NREQ requesters. Each granted write walks a fixed setup / gate-open / hold sequence, so latch D inputs are stable before and after each gate pulse. The block sits between the requesting logic and the latch array. It is the only driver of the latch gates and data.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, latch word width
- ADDR_W, 2, word address width; bank holds 2^ADDR_W words
- OPEN_CYC, 2, gate-open duration in clocks (1..15)

- Clk  in  1  single clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Req  in  NREQ  per-requester write request, level, held until own Done
- Wdata  in  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- Waddr  in  NREQ*ADDR_W  requester i word address at [i*ADDR_W +: ADDR_W]
- Gnt  out  NREQ  one-hot grant, high SETUP through HOLD
- Done  out  NREQ  one-cycle pulse to the granted requester in HOLD
- LatD  out  WIDTH  data bus to all latch words
- LatEn  out  2^ADDR_W  one-hot gate (Clk pin) of addressed latch word
- Busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE: if any Req bit is set, arbitrate, capture winner index, Wdata and Waddr into registers, then go to SETUP. Otherwise stay.
- SETUP: LatD = captured data, Gnt[winner]=1, LatEn=0. Next state is OPEN; load the open counter with OPEN_CYC-1.
- OPEN: LatEn[captured addr]=1, LatD unchanged. Counter decrements each cycle; at 0, go to HOLD.
- HOLD: LatEn=0, LatD unchanged, Done[winner]=1. Next state is always IDLE.
- LatD and the captured address change only on the IDLE->SETUP transition.
- LatEn is never high outside OPEN, and never more than one bit at a time.
- Arbitration is round-robin. The priority pointer starts at 0. After granting i, the pointer becomes (i+1) mod NREQ. Pointer updates only on grant.
- Requester deasserting Req mid-transaction: the transaction still completes and Done still pulses.
- Req from other requesters during a transaction: ignored until the next IDLE.
- Requester re-asserting Req in the cycle after its Done: eligible at the next IDLE, subject to the pointer.

## Timing
- Reset values: Gnt=0, Done=0, LatD=0, LatEn=0, Busy=0, state=IDLE, pointer=0, open counter=0.
- Req sampled high in IDLE at edge t:
  - SETUP during cycle t+1.
  - OPEN during cycles t+2 .. t+1+OPEN_CYC.
  - HOLD with Done during cycle t+2+OPEN_CYC.
  - IDLE during t+3+OPEN_CYC.
- Transaction period is OPEN_CYC+3 clocks, including the mandatory IDLE cycle. Back-to-back writes are never merged.
- Rst mid-operation: all outputs return to reset values on the next edge, and LatEn drops immediately. A latch word in OPEN may be left holding the new data. No Done is issued for the aborted write.
- Rst takes priority over all other inputs.

## Configuration
- LATCH_SEQ_FIXED_PRIO_EN defined: fixed priority, lowest index wins; the pointer register is removed.
- LATCH_SEQ_FIXED_PRIO_EN not defined: round-robin as described above.
- FSM timing is identical in both cases.

## Structure
- Shared package/header latch_seq_pkg holds:
  - state encodings: IDLE=2'd0, SETUP=2'd1, OPEN=2'd2, HOLD=2'd3;
  - the counter width constant, 4 bits.
- One sub-module, latch_seq_rr_arb (combinational): inputs Req and pointer; outputs one-hot winner and its binary index. The fixed-priority variant lives inside it under the macro.
- Top level holds the FSM, capture registers, open counter and the LatEn decoder.

## Test plan
- Single write: Req=4'b0010, Wdata[15:8]=8'hA5, Waddr[3:2]=2'd3, OPEN_CYC=2.
  - Gnt=4'b0010 for 4 cycles.
  - LatEn=4'b1000 for exactly 2 cycles, starting 2 cycles after Req.
  - LatD=8'hA5 from SETUP through HOLD.
  - Done[1] pulses once, then Busy=0.
- All four Req held high, round-robin: grant order 0,1,2,3,0, each transaction 5 clocks apart.
- Same as above with LATCH_SEQ_FIXED_PRIO_EN defined: requester 0 is granted every transaction while it holds Req.
- Req[2] dropped during OPEN: gate pulse is still 2 cycles, Done[2] still pulses, and the next IDLE grants another requester.
- Rst asserted during the second OPEN cycle:
  - next edge gives LatEn=0, Gnt=0, Busy=0, no Done;
  - pointer resets to 0, so a following Req=4'b1111 grants 0.
- OPEN_CYC=1 and OPEN_CYC=15: LatEn width is exactly 1 and 15 cycles; LatD never changes while any LatEn bit is high.
